lbdr_param: RTL

LBDR_PARAM -- requirements
Module: lbdr_param

---
 rtl/lbdr_param.sv | 109 ++++++++++
 1 files changed

// File: rtl/lbdr_param.sv
// lbdr_param: logic-based distributed routing for a 2D mesh router input port
// Ports:
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   cfg_we_i            loads cfg_rxy_i/cfg_cx_i/cfg_cur_i/cfg_dr_i
//   cfg_rxy_i [7:0]     routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cfg_cx_i  [3:0]     connectivity bits {Cs,Cw,Ce,Cn}
//   cfg_cur_i [AW-1:0]  own address {y,x}
//   cfg_dr_i  [1:0]     deroute port 0=N 1=E 2=W 3=S
//   empty_i, flit_id_i, dst_addr_i, pop_i  incoming flit and consume strobe
//   nport_o..lport_o    registered one-hot port request
//   busy_o, err_o       route held / one-cycle error pulse
module lbdr_param #(
  parameter int COORD_W = 2,
  parameter bit DEROUTE_EN = 1'b1,
  parameter logic [7:0] RXY_RST = 8'h3C,
  parameter logic [3:0] CX_RST = 4'hF,
  parameter int CUR_RST = 5,
  localparam int AW = 2*COORD_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_we_i,
  input  logic [7:0]    cfg_rxy_i,
  input  logic [3:0]    cfg_cx_i,
  input  logic [AW-1:0] cfg_cur_i,
  input  logic [1:0]    cfg_dr_i,
  input  logic          empty_i,
  input  logic [2:0]    flit_id_i,
  input  logic [AW-1:0] dst_addr_i,
  input  logic          pop_i,
  output logic          nport_o,
  output logic          eport_o,
  output logic          wport_o,
  output logic          sport_o,
  output logic          lport_o,
  output logic          busy_o,
  output logic          err_o
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [7:0] rxy_q;
  logic [3:0] cx_q;
  logic [AW-1:0] cur_q;
  logic [1:0] dr_q;
  logic [4:0] port_q, port_d;
  logic err_q, err_d;
  logic [COORD_W-1:0] xc, yc, xd, yd;
  logic n1, s1, e1, w1, loc, hdr, body, tail;
  logic [3:0] min_v, sel, dr_v;
  logic [4:0] route;
  assign {yc, xc} = cur_q;
  assign {yd, xd} = dst_addr_i;
  assign n1 = yd < yc;
  assign s1 = yc < yd;
  assign e1 = xc < xd;
  assign w1 = xd < xc;
  assign loc = ~(n1 | s1 | e1 | w1);
  assign min_v[0] = (n1 & ~e1 & ~w1 | n1 & e1 & rxy_q[0] | n1 & w1 & rxy_q[1]) & cx_q[0];
  assign min_v[1] = (e1 & ~n1 & ~s1 | e1 & n1 & rxy_q[2] | e1 & s1 & rxy_q[3]) & cx_q[1];
  assign min_v[2] = (w1 & ~n1 & ~s1 | w1 & n1 & rxy_q[4] | w1 & s1 & rxy_q[5]) & cx_q[2];
  assign min_v[3] = (s1 & ~e1 & ~w1 | s1 & e1 & rxy_q[6] | s1 & w1 & rxy_q[7]) & cx_q[3];
  // N sits at bit 0, so isolating the lowest set bit gives N>E>W>S priority
  assign sel = min_v & (-min_v);
  // cfg_dr encoding matches the cx bit order, so one shift both selects and masks
  assign dr_v = (DEROUTE_EN && !loc && min_v == 4'd0) ? (4'b0001 << dr_q) & cx_q : 4'd0;
  assign route = {loc, (min_v != 4'd0) ? sel : dr_v};
  assign hdr = !empty_i && flit_id_i == 3'b001;
  assign body = !empty_i && flit_id_i == 3'b010;
  assign tail = !empty_i && flit_id_i == 3'b100;
  always_comb begin
    state_d = state_q;
    port_d = port_q;
    err_d = 1'b0;
    if (hdr) begin
      err_d = state_q == HOLD || route == 5'd0;
      state_d = (route != 5'd0) ? HOLD : IDLE;
      port_d = route;
    end else if (state_q == IDLE) begin
      err_d = body | tail;
    end else if (tail && pop_i) begin
      state_d = IDLE;
      port_d = 5'd0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      port_q <= 5'd0;
      err_q <= 1'b0;
      rxy_q <= RXY_RST;
      cx_q <= CX_RST;
      cur_q <= AW'(CUR_RST);
      dr_q <= 2'd0;
    end else begin
      state_q <= state_d;
      port_q <= port_d;
      err_q <= err_d;
      if (cfg_we_i) begin
        rxy_q <= cfg_rxy_i;
        cx_q <= cfg_cx_i;
        cur_q <= cfg_cur_i;
        dr_q <= cfg_dr_i;
      end
    end
  end
  assign {lport_o, sport_o, wport_o, eport_o, nport_o} = port_q;
  assign busy_o = state_q == HOLD;
  assign err_o = err_q;
endmodule
